// File: rtl/nn_pkg.sv
// Shared types and sizes for the NN feed loader: buffer layouts, FSM states, fetch kinds.
package nn_pkg;

   typedef logic [63:0][7:0]    img_buf_t;
   typedef logic [1023:0][15:0] coef_buf_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_FINISH
   } loader_state_e;

   typedef enum logic {
      KIND_IMG,
      KIND_COEF
   } fetch_kind_e;

   localparam int IMG_WORDS  = 16;
   localparam int COEF_WORDS = 512;

endpackage

// File: rtl/nn_word_packer.sv
// Scatters one 32-bit memory word into the image or coefficient buffer at word index idx.
module nn_word_packer
   import nn_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  fetch_kind_e kind,
   input  logic [8:0]  idx,
   input  logic [31:0] word,
   output img_buf_t    image_data,
   output coef_buf_t   coeff_data
);

   // Little-endian: lowest byte / halfword of the word lands at the lowest buffer index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         image_data <= '0;
         coeff_data <= '0;
      end else if (wr_en) begin
         if (kind == KIND_IMG) begin
            for (int i = 0; i < 4; i++) begin
               image_data[{idx[3:0], 2'(i)}] <= word[8*i +: 8];
            end
         end else begin
            coeff_data[{idx, 1'b0}] <= word[15:0];
            coeff_data[{idx, 1'b1}] <= word[31:16];
         end
      end
   end

endmodule

// File: rtl/nn_feed_loader.sv
// Avalon-MM burst loader feeding image bytes and per-layer coefficients to the NN core.
// Optional NN_LOADER_CHECKSUM_EN adds a 16-bit per-job checksum output.
module nn_feed_loader
   import nn_pkg::*;
#(
   parameter int                ADDR_W       = 26,
   parameter logic [ADDR_W-1:0] IMG_BASE     = 'h000000,
   parameter logic [ADDR_W-1:0] COEF_BASE    = 'h000100,
   parameter int                LAYER_STRIDE = 512
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              get_image,
   input  logic              get_coeffs,
   input  logic [1:0]        layer,
   output logic              busy,
   output logic              done,
   output img_buf_t          image_data,
   output coef_buf_t         coeff_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   input  logic              mem_readdatavalid
`ifdef NN_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   loader_state_e     state_q, state_d;
   fetch_kind_e       kind_q;
   logic [ADDR_W-1:0] addr_q;
   logic [9:0]        k_q, count_q;
   logic              pending_q;
   logic [1:0]        pend_layer_q;
   logic              job_start, word_wr, last_word, pend_capture;

   function automatic logic [ADDR_W-1:0] layer_base(input logic [1:0] l);
      return COEF_BASE + ADDR_W'(l) * ADDR_W'(LAYER_STRIDE);
   endfunction

   assign word_wr   = (state_q == ST_RD_WAIT) && mem_readdatavalid;
   assign last_word = (k_q + 10'd1) == count_q;
   assign job_start = ((state_q == ST_IDLE) && (get_image || get_coeffs)) ||
                      ((state_q == ST_FINISH) && pending_q);
   // A coeff request queues behind the image job only; a second one while queued is dropped.
   assign pend_capture = ((state_q == ST_IDLE) && get_image && get_coeffs) ||
                         (((state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT)) &&
                          get_coeffs && (kind_q == KIND_IMG) && !pending_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (get_image || get_coeffs) state_d = ST_RD_REQ;
         ST_RD_REQ:  if (!mem_waitrequest) state_d = ST_RD_WAIT;
         ST_RD_WAIT: if (mem_readdatavalid) state_d = last_word ? ST_FINISH : ST_RD_REQ;
         ST_FINISH:  state_d = pending_q ? ST_RD_REQ : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_read = 1'b0;
      done     = 1'b0;
      busy     = 1'b0;
      unique case (state_q)
         ST_RD_REQ:  begin mem_read = 1'b1; busy = 1'b1; end
         ST_RD_WAIT: busy = 1'b1;
         ST_FINISH:  begin done = 1'b1; busy = pending_q; end
         default:    ;
      endcase
   end

   assign mem_address = addr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kind_q       <= KIND_IMG;
         addr_q       <= '0;
         k_q          <= '0;
         count_q      <= '0;
         pending_q    <= 1'b0;
         pend_layer_q <= '0;
      end else begin
         if ((state_q == ST_IDLE) && get_image) begin
            kind_q  <= KIND_IMG;
            count_q <= 10'(IMG_WORDS);
            addr_q  <= IMG_BASE;
            k_q     <= '0;
         end else if ((state_q == ST_IDLE) && get_coeffs) begin
            kind_q  <= KIND_COEF;
            count_q <= 10'(COEF_WORDS);
            addr_q  <= layer_base(layer);
            k_q     <= '0;
         end else if ((state_q == ST_FINISH) && pending_q) begin
            kind_q  <= KIND_COEF;
            count_q <= 10'(COEF_WORDS);
            addr_q  <= layer_base(pend_layer_q);
            k_q     <= '0;
         end else if (word_wr) begin
            k_q    <= k_q + 10'd1;
            addr_q <= addr_q + ADDR_W'(1);
         end

         if (pend_capture) begin
            pending_q    <= 1'b1;
            pend_layer_q <= layer;
         end else if (state_q == ST_FINISH) begin
            pending_q <= 1'b0;
         end
      end
   end

   nn_word_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (word_wr),
      .kind       (kind_q),
      .idx        (k_q[8:0]),
      .word       (mem_readdata),
      .image_data (image_data),
      .coeff_data (coeff_data)
   );

`ifdef NN_LOADER_CHECKSUM_EN
   logic [15:0] cks_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       cks_q <= '0;
      else if (job_start) cks_q <= '0;
      else if (word_wr)   cks_q <= cks_q + mem_readdata[15:0] + mem_readdata[31:16];
   end

   assign checksum = cks_q;
`else
   logic unused_job_start;
   assign unused_job_start = job_start;
`endif

endmodule

// File: tb/tb_nn_feed_loader.sv
// Directed bench for nn_feed_loader: Avalon slave model with an address scoreboard queue.
module tb_nn_feed_loader;
   import nn_pkg::*;

   logic        clk, reset_n, get_image, get_coeffs;
   logic [1:0]  layer;
   logic        busy, done, mem_read, mem_waitrequest, mem_readdatavalid;
   img_buf_t    image_data;
   coef_buf_t   coeff_data;
   logic [25:0] mem_address;
   logic [31:0] mem_readdata;
`ifdef NN_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int total = 0;
   int bad   = 0;
   int mode  = 0;
   int acc_cnt = 0;
   int stall_left = 0;
   int busy_drop = 0;
   bit watch_busy = 0;
   logic [25:0] stall_addr = '0;
   logic [31:0] exp_addr[$];

   nn_feed_loader dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .get_image         (get_image),
      .get_coeffs        (get_coeffs),
      .layer             (layer),
      .busy              (busy),
      .done              (done),
      .image_data        (image_data),
      .coeff_data        (coeff_data),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid)
`ifdef NN_LOADER_CHECKSUM_EN
      ,
      .checksum          (checksum)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] memword(input logic [25:0] a, input int m);
      if (m == 0)      return {4{a[7:0]}};
      else if (m == 1) return 32'h0001_0002;
      else             return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h1111};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave: decides waitrequest/accept at negedge, returns data one cycle after accept.
   initial begin
      bit          acc_pend, stalled_prev;
      logic [25:0] acc_addr;
      acc_pend = 0; stalled_prev = 0; acc_addr = '0;
      mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         mem_readdatavalid = acc_pend && reset_n;
         mem_readdata      = acc_pend ? memword(acc_addr, mode) : 32'hDEAD_BEEF;
         acc_pend          = 0;
         mem_waitrequest   = 0;
         if (stalled_prev && reset_n) begin
            check("stall_hold_read", {31'b0, mem_read}, 32'd1);
            check("stall_hold_addr", {6'b0, mem_address}, {6'b0, stall_addr});
         end
         stalled_prev = 0;
         if (reset_n && mem_read) begin
            if (stall_left > 0 && mem_address == stall_addr) begin
               mem_waitrequest = 1;
               stall_left--;
               stalled_prev = 1;
            end else begin
               acc_pend = 1;
               acc_addr = mem_address;
               acc_cnt++;
               if (exp_addr.size() == 0) check("unexpected_read", {6'b0, mem_address}, 32'hFFFF_FFFF);
               else check("rd_addr", {6'b0, mem_address}, exp_addr.pop_front());
            end
         end
      end
   end

   always @(negedge clk) if (watch_busy && !busy) busy_drop++;

   task automatic push_job(input logic [25:0] base, input int words);
      for (int k = 0; k < words; k++) exp_addr.push_back({6'b0, base + 26'(k)});
   endtask

   task automatic pulse(input bit img, input bit coef, input logic [1:0] l);
      get_image = img; get_coeffs = coef; layer = l;
      @(negedge clk);
      get_image = 0; get_coeffs = 0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!done && n < max) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
   endtask

   task automatic check_img(input logic [25:0] base, input int m);
      for (int k = 0; k < IMG_WORDS; k++)
         check("img_word", {image_data[4*k+3], image_data[4*k+2], image_data[4*k+1], image_data[4*k]},
               memword(base + 26'(k), m));
   endtask

   task automatic check_coef(input logic [25:0] base, input int m);
      for (int k = 0; k < COEF_WORDS; k++)
         check("coef_word", {coeff_data[2*k+1], coeff_data[2*k]}, memword(base + 26'(k), m));
   endtask

   initial begin
      int n;
      logic [31:0] w0;
      reset_n = 0; get_image = 0; get_coeffs = 0; layer = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_read", {31'b0, mem_read}, 32'd0);
      check("rst_addr", {6'b0, mem_address}, 32'd0);
      check("rst_img_zero", {31'b0, image_data == '0}, 32'd1);
      check("rst_coef_zero", {31'b0, coeff_data == '0}, 32'd1);
      reset_n = 1;
      @(negedge clk);

      // 1: image fetch, zero-wait, latency 34 cycles inclusive of request and done cycles
      mode = 0;
      push_job(26'h0, IMG_WORDS);
      pulse(1, 0, 0);
      check("busy_after_req", {31'b0, busy}, 32'd1);
      wait_done(200, n);
      check("img_latency", n + 2, 32'd34);
      check_img(26'h0, 0);
      check("img_byte13", {24'b0, image_data[13]}, 32'd3);
      @(negedge clk);
      check("done_one_cycle", {31'b0, done}, 32'd0);
      check("busy_idle", {31'b0, busy}, 32'd0);
      check("img_q_empty", exp_addr.size(), 32'd0);

      // 2: coeffs of layer 2 from 0x500..0x6FF
      mode = 2;
      push_job(26'h500, COEF_WORDS);
      pulse(0, 1, 2'd2);
      wait_done(3000, n);
      check_coef(26'h500, 2);
      w0 = memword(26'h500, 2);
      check("coef1_hi", {16'b0, coeff_data[1]}, {16'b0, w0[31:16]});
      check("img_retained", {24'b0, image_data[13]}, 32'd3);
      check("coef_q_empty", exp_addr.size(), 32'd0);
      @(negedge clk);

      // 3: simultaneous requests: image then layer-1 coeffs, busy held across both
      push_job(26'h0, IMG_WORDS);
      push_job(26'h300, COEF_WORDS);
      busy_drop = 0;
      pulse(1, 1, 2'd1);
      watch_busy = 1;
      wait_done(200, n);
      check("first_done_busy", {31'b0, busy}, 32'd1);
      check_img(26'h0, 2);
      @(negedge clk);
      wait_done(3000, n);
      watch_busy = 0;
      check("busy_never_dropped", busy_drop, 32'd0);
      check_coef(26'h300, 2);
      check("dual_q_empty", exp_addr.size(), 32'd0);
      @(negedge clk);
      check("dual_idle", {31'b0, busy}, 32'd0);

      // 4: waitrequest held 5 cycles on word 3
      mode = 0;
      stall_addr = 26'h3;
      stall_left = 5;
      push_job(26'h0, IMG_WORDS);
      pulse(1, 0, 0);
      wait_done(300, n);
      check("stall_latency", n + 2, 32'd39);
      check("stall_consumed", stall_left, 32'd0);
      check_img(26'h0, 0);
      check("stall_q_empty", exp_addr.size(), 32'd0);
      @(negedge clk);

      // 5: async reset in the middle of a coeff fetch
      mode = 2;
      push_job(26'h100, COEF_WORDS);
      n = acc_cnt;
      pulse(0, 1, 2'd0);
      for (int i = 0; i < 500 && acc_cnt < n + 101; i++) @(negedge clk);
      check("reached_word100", acc_cnt - n, 32'd101);
      #2 reset_n = 0;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_read", {31'b0, mem_read}, 32'd0);
      check("mid_rst_img_zero", {31'b0, image_data == '0}, 32'd1);
      check("mid_rst_coef_zero", {31'b0, coeff_data == '0}, 32'd1);
      exp_addr.delete();
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      check("post_rst_idle", {31'b0, busy | mem_read}, 32'd0);
      mode = 0;
      push_job(26'h0, IMG_WORDS);
      pulse(1, 0, 0);
      wait_done(200, n);
      check_img(26'h0, 0);
      @(negedge clk);

`ifdef NN_LOADER_CHECKSUM_EN
      // 6: checksum over 16 words of 0x00010002
      mode = 1;
      push_job(26'h0, IMG_WORDS);
      pulse(1, 0, 0);
      wait_done(200, n);
      check("checksum", {16'b0, checksum}, 32'h0030);
      @(negedge clk);
`endif

      check("final_q_empty", exp_addr.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
